concat_serializer: RTL and testbench

//   Downstream stage of the 16-bit slice/concat rearrangement network.

---
 rtl/concat_serializer.sv | 80 ++++++++
 tb/tb_concat_serializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/concat_serializer.sv
// Word-to-chunk serializer: accepts one WIDTH-bit word per handshake and emits it
// as WIDTH/CHUNK chunks, LSB chunk first, flagging the last chunk of each word.
module concat_serializer #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_alive;

  logic             w_hs;
  logic             w_accept;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_hs      = r_out_valid & out_ready;
  assign w_cnt_nxt = r_cnt + CW'(1);

  // r_alive keeps in_ready low during reset and until the first edge after release.
  assign in_ready  = r_alive & ((r_state == IDLE) | (w_hs & r_out_last));
  assign w_accept  = in_valid & in_ready;

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_sreg[CHUNK-1:0];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= IDLE;
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_alive     <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_accept) begin
        // A new word may load on the same edge the previous last chunk leaves.
        r_state     <= SEND;
        r_sreg      <= in_data;
        r_cnt       <= '0;
        r_out_valid <= 1'b1;
        r_out_last  <= (NCHUNK == 1);
      end else if (w_hs) begin
        if (r_cnt == LAST_CNT) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end else begin
          r_sreg     <= r_sreg >> CHUNK;
          r_cnt      <= w_cnt_nxt;
          r_out_last <= (w_cnt_nxt == LAST_CNT);
        end
      end
    end
  end

endmodule

// File: tb/tb_concat_serializer.sv
// Directed bench for concat_serializer: a 4-bit-chunk instance and a single-chunk instance.
module tb_concat_serializer;

  logic        clk;
  logic        arst_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [15:0] in_data;
  logic [3:0]  out_data;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
  logic [15:0] in_data1;
  logic [15:0] out_data1;

  int total;
  int bad;

  concat_serializer #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  concat_serializer #(.WIDTH(16), .CHUNK(16)) u_dut1 (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_data  (out_data1),
    .out_last  (out_last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the narrow instance's outputs: valid, data, last.
  task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic l);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".last"}, 32'(out_last), 32'(l));
  endtask

  initial begin
    total = 0;
    bad = 0;
    arst_n = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;

    // Reset applied asynchronously
    #1 arst_n = 1'b0;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'(0));
    chk("rst.out_valid", 32'(out_valid), 32'(0));
    chk("rst.out_data", 32'(out_data), 32'(0));
    chk("rst.out_last", 32'(out_last), 32'(0));
    chk("rst.in_ready1", 32'(in_ready1), 32'(0));
    tick(); tick();
    #3 arst_n = 1'b1;
    tick();
    chk("rel.in_ready", 32'(in_ready), 32'(1));
    chk("rel.out_valid", 32'(out_valid), 32'(0));

    // Single word 0xABCD, no backpressure
    in_valid = 1'b1; in_data = 16'hABCD; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_out("w1.c0", 1'b1, 4'hD, 1'b0);
    chk("w1.c0.in_ready", 32'(in_ready), 32'(0));
    tick(); chk_out("w1.c1", 1'b1, 4'hC, 1'b0);
    tick(); chk_out("w1.c2", 1'b1, 4'hB, 1'b0);
    tick(); chk_out("w1.c3", 1'b1, 4'hA, 1'b1);
    chk("w1.c3.in_ready", 32'(in_ready), 32'(1));
    tick(); chk_out("w1.end", 1'b0, 4'h0, 1'b0);

    // Backpressure during the second chunk of 0x1234
    in_valid = 1'b1; in_data = 16'h1234;
    tick();
    in_valid = 1'b0;
    chk_out("bp.c0", 1'b1, 4'h4, 1'b0);
    tick(); chk_out("bp.c1", 1'b1, 4'h3, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp.hold", 1'b1, 4'h3, 1'b0);
      chk("bp.hold.in_ready", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    tick(); chk_out("bp.c2", 1'b1, 4'h2, 1'b0);
    tick(); chk_out("bp.c3", 1'b1, 4'h1, 1'b1);
    tick(); chk_out("bp.end", 1'b0, 4'h0, 1'b0);

    // Back-to-back words with no idle cycle between them
    in_valid = 1'b1; in_data = 16'hABCD;
    tick();
    in_data = 16'h5678;
    chk_out("b2b.c0", 1'b1, 4'hD, 1'b0);
    tick(); chk_out("b2b.c1", 1'b1, 4'hC, 1'b0);
    tick(); chk_out("b2b.c2", 1'b1, 4'hB, 1'b0);
    tick(); chk_out("b2b.c3", 1'b1, 4'hA, 1'b1);
    chk("b2b.c3.in_ready", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    chk_out("b2b.c4", 1'b1, 4'h8, 1'b0);
    tick(); chk_out("b2b.c5", 1'b1, 4'h7, 1'b0);
    tick(); chk_out("b2b.c6", 1'b1, 4'h6, 1'b0);
    tick(); chk_out("b2b.c7", 1'b1, 4'h5, 1'b1);
    tick(); chk_out("b2b.end", 1'b0, 4'h0, 1'b0);

    // in_data changing while a word is being sent must be ignored
    in_valid = 1'b1; in_data = 16'h4321;
    tick();
    in_data = 16'h9999;
    chk_out("ign.c0", 1'b1, 4'h1, 1'b0);
    chk("ign.c0.in_ready", 32'(in_ready), 32'(0));
    tick();
    in_data = 16'h8888;
    chk_out("ign.c1", 1'b1, 4'h2, 1'b0);
    chk("ign.c1.in_ready", 32'(in_ready), 32'(0));
    tick(); chk_out("ign.c2", 1'b1, 4'h3, 1'b0);
    in_valid = 1'b0;
    tick(); chk_out("ign.c3", 1'b1, 4'h4, 1'b1);
    tick(); chk_out("ign.end", 1'b0, 4'h0, 1'b0);

    // Reset in the middle of a word
    in_valid = 1'b1; in_data = 16'hABCD;
    tick();
    in_valid = 1'b0;
    chk_out("mid.c0", 1'b1, 4'hD, 1'b0);
    tick(); chk_out("mid.c1", 1'b1, 4'hC, 1'b0);
    #2 arst_n = 1'b0;
    #1;
    chk("mid.rst.valid", 32'(out_valid), 32'(0));
    chk("mid.rst.data", 32'(out_data), 32'(0));
    chk("mid.rst.last", 32'(out_last), 32'(0));
    chk("mid.rst.in_ready", 32'(in_ready), 32'(0));
    tick();
    #3 arst_n = 1'b1;
    tick();
    chk_out("mid.rel0", 1'b0, 4'h0, 1'b0);
    chk("mid.rel.in_ready", 32'(in_ready), 32'(1));
    tick();
    chk_out("mid.rel1", 1'b0, 4'h0, 1'b0);
    in_valid = 1'b1; in_data = 16'h00F1;
    tick();
    in_valid = 1'b0;
    chk_out("f1.c0", 1'b1, 4'h1, 1'b0);
    tick(); chk_out("f1.c1", 1'b1, 4'hF, 1'b0);
    tick(); chk_out("f1.c2", 1'b1, 4'h0, 1'b0);
    tick(); chk_out("f1.c3", 1'b1, 4'h0, 1'b1);
    tick(); chk_out("f1.end", 1'b0, 4'h0, 1'b0);

    // Single-chunk instance: every chunk is the last one
    in_valid1 = 1'b1; in_data1 = 16'hBEEF; out_ready1 = 1'b1;
    tick();
    in_data1 = 16'h1357;
    chk("one.c0.valid", 32'(out_valid1), 32'(1));
    chk("one.c0.data", 32'(out_data1), 32'(16'hBEEF));
    chk("one.c0.last", 32'(out_last1), 32'(1));
    chk("one.c0.in_ready", 32'(in_ready1), 32'(1));
    tick();
    in_valid1 = 1'b0;
    chk("one.c1.valid", 32'(out_valid1), 32'(1));
    chk("one.c1.data", 32'(out_data1), 32'(16'h1357));
    chk("one.c1.last", 32'(out_last1), 32'(1));
    tick();
    chk("one.end.valid", 32'(out_valid1), 32'(0));
    chk("one.end.last", 32'(out_last1), 32'(0));

    // Single-chunk instance: reset while its chunk is stalled
    in_valid1 = 1'b1; in_data1 = 16'hCAFE; out_ready1 = 1'b0;
    tick();
    in_valid1 = 1'b0;
    chk("one.stall.valid", 32'(out_valid1), 32'(1));
    chk("one.stall.data", 32'(out_data1), 32'(16'hCAFE));
    chk("one.stall.in_ready", 32'(in_ready1), 32'(0));
    #2 arst_n = 1'b0;
    #1;
    chk("one.rst.valid", 32'(out_valid1), 32'(0));
    chk("one.rst.data", 32'(out_data1), 32'(0));
    tick();
    #3 arst_n = 1'b1;
    out_ready1 = 1'b1;
    tick();
    chk("one.rel.valid", 32'(out_valid1), 32'(0));
    chk("one.rel.in_ready", 32'(in_ready1), 32'(1));
    in_valid1 = 1'b1; in_data1 = 16'h00F1;
    tick();
    in_valid1 = 1'b0;
    chk("one.f1.valid", 32'(out_valid1), 32'(1));
    chk("one.f1.data", 32'(out_data1), 32'(16'h00F1));
    chk("one.f1.last", 32'(out_last1), 32'(1));
    tick();
    chk("one.f1.end", 32'(out_valid1), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
